// File: rtl/ctrl_sig_pipe.sv
// Control-signal pipeline: carries decoded control words from ID through DEPTH stage
// registers with per-stage field masking, valid tracking, bubble/stall/flush control.
module ctrl_sig_pipe #(
   parameter int                     WIDTH       = 21,
   parameter int                     DEPTH       = 3,
   parameter logic [WIDTH-1:0]       NOP_VALUE   = {WIDTH{1'b0}},
   parameter logic [DEPTH*WIDTH-1:0] STAGE_MASK  = {DEPTH{{WIDTH{1'b1}}}},
   parameter int                     FLUSH_DEPTH = 1,
   parameter int                     CNT_W       = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     LE,
   input  logic                     S,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         ctrl_in,
   input  logic                     valid_in,
   output logic [DEPTH*WIDTH-1:0]   stage_ctrl,
   output logic [DEPTH-1:0]         stage_valid,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] stage_q    [DEPTH];
   logic [WIDTH-1:0] stage_next [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_next;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;
   logic             insert_nop;
   logic             advance;

   assign insert_nop = flush | S;
   assign advance    = flush | S | LE;

   // Next contents assuming the pipe advances; masking is applied on entry to each stage
   // so a field cleared upstream can never reappear further down.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         stage_next[k] = NOP_VALUE & STAGE_MASK[k*WIDTH +: WIDTH];
         valid_next[k] = 1'b0;
         if (!(flush && (k < FLUSH_DEPTH))) begin
            if (k == 0) begin
               if (!insert_nop) begin
                  stage_next[k] = ctrl_in & STAGE_MASK[k*WIDTH +: WIDTH];
                  valid_next[k] = valid_in;
               end
            end else begin
               stage_next[k] = stage_q[k-1] & STAGE_MASK[k*WIDTH +: WIDTH];
               valid_next[k] = valid_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= NOP_VALUE & STAGE_MASK[k*WIDTH +: WIDTH];
         end
         valid_q <= '0;
      end else if (advance) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= stage_next[k];
         end
         valid_q <= valid_next;
      end
   end

   // Counters saturate instead of wrapping so a long stall never looks like a short one.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else if (insert_nop) begin
         if (bubble_q != CNT_MAX) bubble_q <= bubble_q + CNT_ONE;
      end else if (!LE) begin
         if (stall_q != CNT_MAX) stall_q <= stall_q + CNT_ONE;
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         stage_ctrl[k*WIDTH +: WIDTH] = stage_q[k];
      end
   end

   assign stage_valid = valid_q;
   assign stall_cnt   = stall_q;
   assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_ctrl_sig_pipe.sv
// Self-checking bench for ctrl_sig_pipe: two differently parameterised instances share
// one directed stimulus stream and are compared every cycle against a list-based model.
module tb_ctrl_sig_pipe;

   logic        Clk;
   logic        Rst;
   logic        LE;
   logic        S;
   logic        flush;
   logic [20:0] ctrl_in;
   logic        valid_in;

   logic [62:0] a_ctrl;
   logic [2:0]  a_valid;
   logic [3:0]  a_stall;
   logic [3:0]  a_bub;
   logic [62:0] b_ctrl;
   logic [2:0]  b_valid;
   logic [15:0] b_stall;
   logic [15:0] b_bub;

   int checks   = 0;
   int failures = 0;

   // Instance A: full masks, two-stage flush, narrow counters.
   ctrl_sig_pipe #(
      .WIDTH(21), .DEPTH(3), .FLUSH_DEPTH(2), .CNT_W(4)
   ) dut_a (
      .Clk(Clk), .Rst(Rst), .LE(LE), .S(S), .flush(flush),
      .ctrl_in(ctrl_in), .valid_in(valid_in),
      .stage_ctrl(a_ctrl), .stage_valid(a_valid),
      .stall_cnt(a_stall), .bubble_cnt(a_bub)
   );

   // Instance B: trimmed fields in stages 2 and 3.
   ctrl_sig_pipe #(
      .WIDTH(21), .DEPTH(3),
      .STAGE_MASK({21'h000002, 21'h00003F, 21'h1FFFFF}),
      .FLUSH_DEPTH(1), .CNT_W(16)
   ) dut_b (
      .Clk(Clk), .Rst(Rst), .LE(LE), .S(S), .flush(flush),
      .ctrl_in(ctrl_in), .valid_in(valid_in),
      .stage_ctrl(b_ctrl), .stage_valid(b_valid),
      .stall_cnt(b_stall), .bubble_cnt(b_bub)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [20:0] mmask [2][3] = '{'{21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF},
                                 '{21'h1FFFFF, 21'h00003F, 21'h000002}};
   int          mfd   [2]    = '{2, 1};
   int          mmax  [2]    = '{15, 65535};
   logic [20:0] mc    [2][3];
   logic        mv    [2][3];
   int          mstall[2];
   int          mbub  [2];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // The model treats each instance as a list of (word, valid) slots: an advancing edge
   // pushes a new slot at the front and drops the last, then flush/masks are applied.
   task automatic modelUpdate();
      for (int i = 0; i < 2; i++) begin
         if (Rst) begin
            for (int k = 0; k < 3; k++) begin
               mc[i][k] = '0;
               mv[i][k] = 1'b0;
            end
            mstall[i] = 0;
            mbub[i]   = 0;
         end else if (flush || S || LE) begin
            for (int k = 2; k > 0; k--) begin
               mc[i][k] = mc[i][k-1];
               mv[i][k] = mv[i][k-1];
            end
            mc[i][0] = (flush || S) ? 21'h0 : ctrl_in;
            mv[i][0] = !(flush || S) && valid_in;
            if (flush) begin
               for (int k = 0; k < mfd[i]; k++) begin
                  mc[i][k] = '0;
                  mv[i][k] = 1'b0;
               end
            end
            for (int k = 0; k < 3; k++) mc[i][k] = mc[i][k] & mmask[i][k];
            if ((flush || S) && mbub[i] < mmax[i]) mbub[i]++;
         end else if (mstall[i] < mmax[i]) begin
            mstall[i]++;
         end
      end
   endtask

   always @(posedge Clk) begin
      modelUpdate();
      #2;
      checkOutput("a_ctrl",   {1'b0, a_ctrl},  {1'b0, mc[0][2], mc[0][1], mc[0][0]});
      checkOutput("a_valid",  {61'b0, a_valid}, {61'b0, mv[0][2], mv[0][1], mv[0][0]});
      checkOutput("a_stall",  {60'b0, a_stall}, 64'(mstall[0]));
      checkOutput("a_bubble", {60'b0, a_bub},   64'(mbub[0]));
      checkOutput("b_ctrl",   {1'b0, b_ctrl},  {1'b0, mc[1][2], mc[1][1], mc[1][0]});
      checkOutput("b_valid",  {61'b0, b_valid}, {61'b0, mv[1][2], mv[1][1], mv[1][0]});
      checkOutput("b_stall",  {48'b0, b_stall}, 64'(mstall[1]));
      checkOutput("b_bubble", {48'b0, b_bub},   64'(mbub[1]));
   end

   // Inputs change on the falling edge; the task returns shortly after the next rising edge.
   task automatic applyStimulus(input logic r, input logic le, input logic s, input logic fl,
                                input logic [20:0] word, input logic v);
      @(negedge Clk);
      Rst      = r;
      LE       = le;
      S        = s;
      flush    = fl;
      ctrl_in  = word;
      valid_in = v;
      @(posedge Clk);
      #3;
   endtask

   initial begin
      Rst = 1'b1; LE = 1'b0; S = 1'b0; flush = 1'b0; ctrl_in = '0; valid_in = 1'b0;

      applyStimulus(1, 0, 0, 0, 21'h0, 0);
      applyStimulus(1, 0, 0, 0, 21'h0, 0);
      checkOutput("lit_reset_ctrl",  {1'b0, a_ctrl}, 64'h0);
      checkOutput("lit_reset_valid", {61'b0, a_valid}, 64'h0);
      checkOutput("lit_reset_cnt",   {56'b0, a_stall, a_bub}, 64'h0);

      applyStimulus(0, 1, 0, 0, 21'h1FFFFF, 1);
      applyStimulus(0, 1, 0, 0, 21'h0AAAAA, 1);
      applyStimulus(0, 1, 0, 0, 21'h155555, 1);
      checkOutput("lit_fill_stage3", {43'b0, a_ctrl[62:42]}, 64'h1FFFFF);
      checkOutput("lit_fill_stage1", {43'b0, a_ctrl[20:0]},  64'h155555);
      checkOutput("lit_fill_valid",  {61'b0, a_valid}, 64'h7);

      for (int n = 0; n < 3; n++) applyStimulus(0, 1, 0, 0, 21'h1FFFFF, 1);
      checkOutput("lit_mask_stage2", {43'b0, b_ctrl[41:21]}, 64'h3F);
      checkOutput("lit_mask_stage3", {43'b0, b_ctrl[62:42]}, 64'h2);

      for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 0, 21'h0AAAAA, 1);
      checkOutput("lit_stall_cnt",  {60'b0, a_stall}, 64'd4);
      checkOutput("lit_stall_hold", {1'b0, a_ctrl}, {1'b0, {3{21'h1FFFFF}}});
      applyStimulus(0, 0, 1, 0, 21'h0AAAAA, 1);
      checkOutput("lit_bubble_ctrl",  {1'b0, a_ctrl}, {1'b0, 21'h1FFFFF, 21'h1FFFFF, 21'h0});
      checkOutput("lit_bubble_valid", {61'b0, a_valid}, 64'h6);
      checkOutput("lit_bubble_cnt",   {60'b0, a_bub}, 64'd1);

      applyStimulus(0, 1, 0, 0, 21'h111111, 1);
      applyStimulus(0, 1, 0, 0, 21'h022222, 1);
      applyStimulus(0, 1, 0, 0, 21'h033333, 0);
      applyStimulus(0, 0, 1, 1, 21'h044444, 1);
      checkOutput("lit_flush_ctrl",  {1'b0, a_ctrl}, {1'b0, 21'h022222, 42'h0});
      checkOutput("lit_flush_valid", {61'b0, a_valid}, 64'h4);
      checkOutput("lit_flush_cnts",  {56'b0, a_stall, a_bub}, {56'b0, 4'd4, 4'd2});

      for (int n = 0; n < 20; n++) applyStimulus(0, 0, 0, 0, 21'h055555, 1);
      checkOutput("lit_stall_sat", {60'b0, a_stall}, 64'd15);
      applyStimulus(1, 1, 1, 1, 21'h066666, 1);
      checkOutput("lit_midrst_state", {a_ctrl, a_valid[0]}, 64'h0);
      checkOutput("lit_midrst_cnts",  {56'b0, a_stall, a_bub}, 64'h0);
      for (int n = 0; n < 3; n++) applyStimulus(0, 0, 0, 0, 21'h077777, 1);
      checkOutput("lit_post_rst_stall", {60'b0, a_stall}, 64'd3);
      applyStimulus(0, 1, 0, 0, 21'h0ABCDE, 1);
      checkOutput("lit_first_capture", {43'b0, a_ctrl[20:0]}, 64'h0ABCDE);

      applyStimulus(0, 0, 0, 0, 21'h0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
